// File: rtl/fifo_ch_reader_pkg.sv
// fifo_ch_reader_pkg -- shared definitions for the BCH delay-FIFO reader.
//   state_t      : reader FSM encoding (IDLE / DRAIN / FLUSH), 2 bits
//   skid_data_t  : one skid-buffer entry {corrected bit, last flag}
//   cnt_w_for()  : minimum bit-counter width for a given codeword length
package fifo_ch_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic corr_bit;
    logic last;
  } skid_data_t;

  // Smallest w with 2**w >= len (at least 1).
  function automatic int unsigned cnt_w_for(input int unsigned len);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < len) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/fifo_ch_reader_if.sv
// fifo_ch_reader_if -- corrected-bit output stream of fifo_ch_reader.
//   out_bit   : corrected bit
//   out_valid : out_bit/out_last valid
//   out_last  : final bit of the codeword
//   in_ready  : downstream accepts when out_valid & in_ready
// master = reader side, slave = downstream consumer.
interface fifo_ch_reader_if;
  logic out_bit;
  logic out_valid;
  logic out_last;
  logic in_ready;

  modport master (output out_bit, output out_valid, output out_last, input in_ready);
  modport slave  (input out_bit, input out_valid, input out_last, output in_ready);
endinterface

// File: rtl/fifo_ch_skid2.sv
// fifo_ch_skid2 -- 2-entry valid/ready skid buffer carrying {bit,last}.
//   clk, rst    : clock, synchronous active-high reset
//   push_data   : entry to store; push_valid stores it this cycle
//   push_ready  : a free entry exists (depends on fill level only)
//   pop_data    : oldest entry; pop_valid when non-empty
//   pop_ready   : consumer takes pop_data when pop_valid & pop_ready
module fifo_ch_skid2
  import fifo_ch_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  skid_data_t push_data,
  input  logic       push_valid,
  output logic       push_ready,
  output skid_data_t pop_data,
  output logic       pop_valid,
  input  logic       pop_ready
);

  skid_data_t ent0;  // head
  skid_data_t ent1;
  logic [1:0] fill;
  logic       push;
  logic       pop;

  assign push       = push_valid;
  assign pop        = pop_valid & pop_ready;
  assign push_ready = (fill != 2'd2);
  assign pop_valid  = (fill != 2'd0);
  assign pop_data   = ent0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      assert (!(push && !pop && fill == 2'd2));
      unique case ({push, pop})
        2'b10: begin
          if (fill == 2'd0) ent0 <= push_data;
          else              ent1 <= push_data;
          fill <= fill + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          fill <= fill - 2'd1;
        end
        2'b11: begin
          if (fill == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_ch_reader.sv
// fifo_ch_reader -- consumer end of the BCH codeword delay FIFO.
// Drains CODEWORD_LEN bits per in_start, XORs each with its Chien error flag
// and streams the corrected bits through a 2-entry skid buffer.
//   clk          : clock, rising edge
//   in_ctr_Srst  : synchronous active-high reset
//   in_start     : begin draining one codeword (accepted only in IDLE)
//   in_fifo_bit  : delay-FIFO output bit
//   in_err_bit   : Chien error flag aligned with in_fifo_bit
//   out_fifo_en  : shift strobe to the delay FIFO and the Chien stage
//   out_busy     : codeword in progress
//   out_corr_cnt : corrected-bit count (only with FIFO_CH_READER_CORR_CNT_EN)
//   bus          : corrected-bit stream (out_bit/out_valid/out_last/in_ready)
module fifo_ch_reader
  import fifo_ch_reader_pkg::*;
#(
  parameter int unsigned CODEWORD_LEN = 255,
  parameter int unsigned CNT_W        = cnt_w_for(CODEWORD_LEN)
) (
  input  logic             clk,
  input  logic             in_ctr_Srst,
  input  logic             in_start,
  input  logic             in_fifo_bit,
  input  logic             in_err_bit,
  output logic             out_fifo_en,
  output logic             out_busy,
`ifdef FIFO_CH_READER_CORR_CNT_EN
  output logic [CNT_W-1:0] out_corr_cnt,
`endif
  fifo_ch_reader_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CODEWORD_LEN - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             rd_last;
  logic             skid_ready;
  logic             skid_valid;
  logic             last_pop;
  skid_data_t       skid_in;
  skid_data_t       skid_out;

  assign rd_last = (cnt == LAST_IDX);
  assign skid_in = '{corr_bit: in_fifo_bit ^ in_err_bit, last: rd_last};

  // In FLUSH the last-flagged entry is the only one left, so handing it off
  // empties the skid; leaving FLUSH on that edge drops out_busy with it.
  assign last_pop = skid_valid & bus.in_ready & skid_out.last;

  always_ff @(posedge clk) begin
    if (in_ctr_Srst) state <= ST_IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (in_start)               state_nx = ST_DRAIN;
      ST_DRAIN: if (out_fifo_en && rd_last) state_nx = ST_FLUSH;
      ST_FLUSH: if (last_pop)               state_nx = ST_IDLE;
      default:                              state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    out_fifo_en = (state == ST_DRAIN) && skid_ready;
    out_busy    = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (in_ctr_Srst)      cnt <= '0;
    else if (out_fifo_en) cnt <= rd_last ? '0 : cnt + CNT_W'(1);
  end

`ifdef FIFO_CH_READER_CORR_CNT_EN
  logic [CNT_W-1:0] corr_cnt;

  always_ff @(posedge clk) begin
    if (in_ctr_Srst)                           corr_cnt <= '0;
    else if (state == ST_IDLE && in_start)     corr_cnt <= '0;
    else if (out_fifo_en && in_err_bit)        corr_cnt <= corr_cnt + CNT_W'(1);
  end

  assign out_corr_cnt = corr_cnt;
`endif

  fifo_ch_skid2 u_skid (
    .clk        (clk),
    .rst        (in_ctr_Srst),
    .push_data  (skid_in),
    .push_valid (out_fifo_en),
    .push_ready (skid_ready),
    .pop_data   (skid_out),
    .pop_valid  (skid_valid),
    .pop_ready  (bus.in_ready)
  );

  // Entries behind a pop keep stale contents; hold the outputs low when empty.
  assign bus.out_valid = skid_valid;
  assign bus.out_bit   = skid_valid & skid_out.corr_bit;
  assign bus.out_last  = skid_valid & skid_out.last;

endmodule

// File: tb/tb_fifo_ch_reader.sv
// tb_fifo_ch_reader -- directed bench for fifo_ch_reader with CODEWORD_LEN=8.
// The delay FIFO and Chien flags are modelled as bit arrays indexed by a head
// pointer that advances on out_fifo_en; handed-off bits are collected at negedge.
module tb_fifo_ch_reader;
  import fifo_ch_reader_pkg::*;

  logic clk = 1'b0;
  logic in_ctr_Srst, in_start, in_fifo_bit, in_err_bit, out_fifo_en, out_busy;
`ifdef FIFO_CH_READER_CORR_CNT_EN
  logic [2:0] out_corr_cnt;
`endif
  fifo_ch_reader_if bus();

  int total = 0;
  int bad   = 0;
  bit fifo_mem [0:1023];
  bit err_mem  [0:1023];
  int ptr = 0;
  logic [1:0] rx_q [$];

  always #5 clk = ~clk;

  fifo_ch_reader #(.CODEWORD_LEN(8), .CNT_W(3)) dut (
    .clk          (clk),
    .in_ctr_Srst  (in_ctr_Srst),
    .in_start     (in_start),
    .in_fifo_bit  (in_fifo_bit),
    .in_err_bit   (in_err_bit),
    .out_fifo_en  (out_fifo_en),
    .out_busy     (out_busy),
`ifdef FIFO_CH_READER_CORR_CNT_EN
    .out_corr_cnt (out_corr_cnt),
`endif
    .bus          (bus)
  );

  assign in_fifo_bit = fifo_mem[ptr];
  assign in_err_bit  = err_mem[ptr];

  always @(posedge clk) if (out_fifo_en === 1'b1) ptr <= (ptr + 1) % 1024;

  always @(negedge clk)
    if (bus.out_valid === 1'b1 && bus.in_ready === 1'b1)
      rx_q.push_back({bus.out_bit, bus.out_last});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Index 0 of the codeword is the MSB of d/e.
  task automatic load8(input int base, input logic [7:0] d, input logic [7:0] e);
    for (int i = 0; i < 8; i++) begin
      fifo_mem[base + i] = d[7 - i];
      err_mem[base + i]  = e[7 - i];
    end
  endtask

  task automatic start_cw();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (out_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] exp);
    logic [1:0] e;
    chk($sformatf("%s_count", tag), 32'(rx_q.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      e = (rx_q.size() > 0) ? rx_q.pop_front() : 2'bxx;
      chk($sformatf("%s_bit%0d", tag, i), 32'(e[1]), 32'(exp[7 - i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(e[0]), 32'(i == 7));
    end
  endtask

  initial begin
    int base;
    int cyc;
    int started;
    int lasts;
    logic [7:0] exp1;
    logic [1:0] e;

    in_ctr_Srst  = 1'b1;
    in_start     = 1'b0;
    bus.in_ready = 1'b1;
    tick();
    tick();
    chk("rst_fifo_en", 32'(out_fifo_en), 32'd0);
    chk("rst_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_bit",     32'(bus.out_bit), 32'd0);
    chk("rst_last",    32'(bus.out_last), 32'd0);
    chk("rst_busy",    32'(out_busy), 32'd0);
    chk("rst_state",   32'(dut.state), 32'(ST_IDLE));
`ifdef FIFO_CH_READER_CORR_CNT_EN
    chk("rst_corr_cnt", 32'(out_corr_cnt), 32'd0);
`endif
    in_ctr_Srst = 1'b0;
    tick();

    // 1: plain drain, no errors, cycle-by-cycle
    base = ptr;
    exp1 = 8'b1011_0010;
    load8(base, exp1, 8'h00);
    start_cw();
    for (int c = 0; c <= 8; c++) begin
      chk($sformatf("t1_en%0d", c), 32'(out_fifo_en), 32'(c < 8));
      chk($sformatf("t1_valid%0d", c), 32'(bus.out_valid), 32'(c > 0));
      chk($sformatf("t1_busy%0d", c), 32'(out_busy), 32'd1);
      if (c > 0) begin
        chk($sformatf("t1_bit%0d", c - 1), 32'(bus.out_bit), 32'(exp1[8 - c]));
        chk($sformatf("t1_last%0d", c - 1), 32'(bus.out_last), 32'(c == 8));
      end
      tick();
    end
    chk("t1_busy_end", 32'(out_busy), 32'd0);
    chk("t1_valid_end", 32'(bus.out_valid), 32'd0);
    chk("t1_reads", 32'(ptr), 32'(base + 8));
`ifdef FIFO_CH_READER_CORR_CNT_EN
    chk("t1_corr_cnt", 32'(out_corr_cnt), 32'd0);
`endif
    rx_q.delete();

    // 2: errors at indices 0 and 5
    base = ptr;
    load8(base, 8'b1011_0010, 8'b1000_0100);
    start_cw();
    wait_idle("t2_idle", 50);
    check_stream("t2", 8'b0011_0110);
    tick();
`ifdef FIFO_CH_READER_CORR_CNT_EN
    chk("t2_corr_cnt", 32'(out_corr_cnt), 32'd2);
`endif

    // 3: back-pressure for 5 cycles mid-codeword
    rx_q.delete();
    base = ptr;
    load8(base, 8'b1100_1010, 8'h00);
    start_cw();
    tick();
    tick();
    tick();
    bus.in_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_en%0d", k), 32'(out_fifo_en), 32'(k == 0));
      chk($sformatf("t3_valid%0d", k), 32'(bus.out_valid), 32'd1);
      tick();
    end
    chk("t3_reads_held", 32'(ptr), 32'(base + 4));
    bus.in_ready = 1'b1;
    wait_idle("t3_idle", 50);
    check_stream("t3", 8'b1100_1010);
    chk("t3_reads", 32'(ptr), 32'(base + 8));

    // 4: reset while bit 3 is being read
    rx_q.delete();
    base = ptr;
    load8(base, 8'b1111_0000, 8'h00);
    load8(base + 4, 8'b0110_1001, 8'b0001_0000);
    start_cw();
    tick();
    tick();
    tick();
    chk("t4_head_at_bit3", 32'(ptr), 32'(base + 3));
    in_ctr_Srst = 1'b1;
    tick();
    in_ctr_Srst = 1'b0;
    chk("t4_en",    32'(out_fifo_en), 32'd0);
    chk("t4_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_bit",   32'(bus.out_bit), 32'd0);
    chk("t4_last",  32'(bus.out_last), 32'd0);
    chk("t4_busy",  32'(out_busy), 32'd0);
    chk("t4_state", 32'(dut.state), 32'(ST_IDLE));
    chk("t4_head",  32'(ptr), 32'(base + 4));
`ifdef FIFO_CH_READER_CORR_CNT_EN
    chk("t4_corr_cnt_rst", 32'(out_corr_cnt), 32'd0);
`endif
    rx_q.delete();
    tick();
    tick();
    tick();
    chk("t4_no_partial", 32'(rx_q.size()), 32'd0);
    start_cw();
    wait_idle("t4_idle", 50);
    check_stream("t4", 8'b0111_1001);
`ifdef FIFO_CH_READER_CORR_CNT_EN
    chk("t4_corr_cnt", 32'(out_corr_cnt), 32'd1);
`endif

    // 5: in_start ignored in DRAIN/FLUSH; back-to-back after IDLE re-entry
    rx_q.delete();
    base = ptr;
    load8(base, 8'b1001_1100, 8'h00);
    load8(base + 8, 8'b0101_0011, 8'h00);
    start_cw();
    tick();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("t5_flush", 32'(dut.state), 32'(ST_FLUSH));
    chk("t5_flush_last", 32'(bus.out_last), 32'd1);
    in_start = 1'b1;
    tick();
    chk("t5_idle_busy", 32'(out_busy), 32'd0);
    chk("t5_idle_en", 32'(out_fifo_en), 32'd0);
    tick();
    in_start = 1'b0;
    chk("t5_accept_busy", 32'(out_busy), 32'd1);
    chk("t5_accept_en", 32'(out_fifo_en), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t5_gapfree%0d", k), 32'(bus.out_valid), 32'd1);
    end
    wait_idle("t5_idle", 50);
    check_stream("t5a", 8'b1001_1100);
    check_stream("t5b", 8'b0101_0011);
    chk("t5_reads", 32'(ptr), 32'(base + 16));

    // 6: 100 random codewords under 50% in_ready
    rx_q.delete();
    base = ptr;
    for (int i = 0; i < 800; i++) begin
      fifo_mem[base + i] = 1'($urandom_range(0, 1));
      err_mem[base + i]  = 1'($urandom_range(0, 1));
    end
    cyc = 0;
    started = 0;
    while ((rx_q.size() < 800 || out_busy !== 1'b0) && cyc < 20000) begin
      bus.in_ready = 1'($urandom_range(0, 1));
      in_start = (started < 100) && (out_busy === 1'b0);
      if (in_start) started++;
      tick();
      cyc++;
    end
    in_start = 1'b0;
    bus.in_ready = 1'b1;
    chk("t6_timeout", 32'(cyc < 20000), 32'd1);
    chk("t6_count", 32'(rx_q.size()), 32'd800);
    lasts = 0;
    for (int i = 0; i < 800; i++) begin
      e = (rx_q.size() > 0) ? rx_q.pop_front() : 2'bxx;
      if (e[0] === 1'b1) lasts++;
      chk($sformatf("t6_bit%0d", i), 32'(e[1]), 32'(fifo_mem[base + i] ^ err_mem[base + i]));
      chk($sformatf("t6_last%0d", i), 32'(e[0]), 32'(i % 8 == 7));
    end
    chk("t6_lasts", 32'(lasts), 32'd100);
    chk("t6_reads", 32'(ptr), 32'(base + 800));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
